// File: rtl/csr_perf_counters.sv
// ----------------------------------------------------------------------------
// csr_perf_counters
//   Machine-mode performance counters fed by the writeback stage: mcycle,
//   minstret and mcountinhibit, plus their read-only user shadows. Reads are
//   combinational for the execute-stage CSR read mux; writes arrive from the
//   writeback CSR write port.
//
// Optional feature (macro CSR_PERF_HPM_STALL_EN):
//   Adds mhpmcounter3 / hpmcounter3, which counts writeback stall cycles
//   (valid_w_i & stall_w_i), and makes mcountinhibit[3] writable.
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   valid_w_i      writeback holds a valid instruction
//   stall_w_i      writeback stalled this cycle
//   csr_we_w_i     CSR write strobe
//   csr_addr_w_i   CSR write address
//   csr_wdata_w_i  CSR write data (already RW/RS/RC resolved)
//   csr_raddr_i    CSR read address
//   csr_rdata_o    CSR read data (combinational)
//   csr_hit_o      read address maps to a CSR of this block (combinational)
// ----------------------------------------------------------------------------
module csr_perf_counters #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_w_i,
  input  logic        stall_w_i,
  input  logic        csr_we_w_i,
  input  logic [11:0] csr_addr_w_i,
  input  logic [31:0] csr_wdata_w_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_hit_o
);

  localparam int unsigned HI_W = CNT_WIDTH - 32;

  localparam logic [11:0] ADDR_MCYCLE     = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH    = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET   = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH  = 12'hB82;
  localparam logic [11:0] ADDR_MCNTINHIB  = 12'h320;
  localparam logic [11:0] ADDR_CYCLE      = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH     = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET    = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH   = 12'hC82;
`ifdef CSR_PERF_HPM_STALL_EN
  localparam logic [11:0] ADDR_MHPM3      = 12'hB03;
  localparam logic [11:0] ADDR_MHPM3H     = 12'hB83;
  localparam logic [11:0] ADDR_HPM3       = 12'hC03;
  localparam logic [11:0] ADDR_HPM3H      = 12'hC83;
`endif

  logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d;
  logic [CNT_WIDTH-1:0] minstret_q, minstret_d;
  logic                 inh_cy_q, inh_cy_d;
  logic                 inh_ir_q, inh_ir_d;
  logic [31:0]          inhibit_rd;
  logic                 retire;
  logic                 wr_en;

  // Low write replaces [31:0], high write replaces the upper bits; either
  // write suppresses the increment for that edge.
  function automatic logic [CNT_WIDTH-1:0] cnt_update(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 we_lo,
    input logic                 we_hi,
    input logic [31:0]          wdata
  );
    logic [CNT_WIDTH-1:0] res;
    res = cur;
    if (we_lo) begin
      res = {cur[CNT_WIDTH-1:32], wdata};
    end else if (we_hi) begin
      res = {wdata[HI_W-1:0], cur[31:0]};
    end else if (inc) begin
      res = cur + CNT_WIDTH'(1);
    end
    return res;
  endfunction

  assign retire = valid_w_i & ~stall_w_i;
  assign wr_en  = csr_we_w_i;

`ifdef CSR_PERF_HPM_STALL_EN
  logic [CNT_WIDTH-1:0] mhpm3_q, mhpm3_d;
  logic                 inh_hpm_q, inh_hpm_d;

  // Stall-cycle counter next state
  always_comb begin
    mhpm3_d   = cnt_update(mhpm3_q, valid_w_i & stall_w_i & ~inh_hpm_q,
                           wr_en && (csr_addr_w_i == ADDR_MHPM3),
                           wr_en && (csr_addr_w_i == ADDR_MHPM3H),
                           csr_wdata_w_i);
    inh_hpm_d = inh_hpm_q;
    if (wr_en && (csr_addr_w_i == ADDR_MCNTINHIB)) begin
      inh_hpm_d = csr_wdata_w_i[3];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mhpm3_q   <= '0;
      inh_hpm_q <= 1'b0;
    end else begin
      mhpm3_q   <= mhpm3_d;
      inh_hpm_q <= inh_hpm_d;
    end
  end

  assign inhibit_rd = {28'd0, inh_hpm_q, inh_ir_q, 1'b0, inh_cy_q};
`else
  assign inhibit_rd = {29'd0, inh_ir_q, 1'b0, inh_cy_q};
`endif

  // Architectural counter and inhibit next state
  always_comb begin
    mcycle_d   = cnt_update(mcycle_q, ~inh_cy_q,
                            wr_en && (csr_addr_w_i == ADDR_MCYCLE),
                            wr_en && (csr_addr_w_i == ADDR_MCYCLEH),
                            csr_wdata_w_i);
    minstret_d = cnt_update(minstret_q, retire & ~inh_ir_q,
                            wr_en && (csr_addr_w_i == ADDR_MINSTRET),
                            wr_en && (csr_addr_w_i == ADDR_MINSTRETH),
                            csr_wdata_w_i);
    inh_cy_d   = inh_cy_q;
    inh_ir_d   = inh_ir_q;
    if (wr_en && (csr_addr_w_i == ADDR_MCNTINHIB)) begin
      inh_cy_d = csr_wdata_w_i[0];
      inh_ir_d = csr_wdata_w_i[2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inh_cy_q   <= 1'b0;
      inh_ir_q   <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inh_cy_q   <= inh_cy_d;
      inh_ir_q   <= inh_ir_d;
    end
  end

  // Read mux; gated while reset is held so reads are 0 even before the
  // first reset edge has cleared the flops.
  logic [31:0] rdata;
  logic        hit;

  always_comb begin
    rdata = 32'd0;
    hit   = 1'b1;
    case (csr_raddr_i)
      ADDR_MCYCLE,    ADDR_CYCLE:    rdata = mcycle_q[31:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   rdata = 32'(mcycle_q[CNT_WIDTH-1:32]);
      ADDR_MINSTRET,  ADDR_INSTRET:  rdata = minstret_q[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: rdata = 32'(minstret_q[CNT_WIDTH-1:32]);
      ADDR_MCNTINHIB:                rdata = inhibit_rd;
`ifdef CSR_PERF_HPM_STALL_EN
      ADDR_MHPM3,     ADDR_HPM3:     rdata = mhpm3_q[31:0];
      ADDR_MHPM3H,    ADDR_HPM3H:    rdata = 32'(mhpm3_q[CNT_WIDTH-1:32]);
`endif
      default:                       hit   = 1'b0;
    endcase
  end

  assign csr_rdata_o = reset_i ? 32'd0 : rdata;
  assign csr_hit_o   = hit;

endmodule

// File: tb/tb_csr_perf_counters.sv
// ----------------------------------------------------------------------------
// tb_csr_perf_counters
//   Self-checking bench for csr_perf_counters (CNT_WIDTH=64). A 64-bit
//   arithmetic model of the counters is advanced once per clock edge and
//   every CSR read is compared against it.
// ----------------------------------------------------------------------------
module tb_csr_perf_counters;

  logic        clk;
  logic        reset;
  logic        valid_w;
  logic        stall_w;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_hit;

  int checks = 0;
  int errors = 0;

  csr_perf_counters #(.CNT_WIDTH(64)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .valid_w_i     (valid_w),
    .stall_w_i     (stall_w),
    .csr_we_w_i    (csr_we),
    .csr_addr_w_i  (csr_waddr),
    .csr_wdata_w_i (csr_wdata),
    .csr_raddr_i   (csr_raddr),
    .csr_rdata_o   (csr_rdata),
    .csr_hit_o     (csr_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CSR_PERF_HPM_STALL_EN
  localparam logic [31:0] INH_MASK = 32'hD;
`else
  localparam logic [31:0] INH_MASK = 32'h5;
`endif

  // Reference model state
  logic [63:0] m_cyc = '0;
  logic [63:0] m_ins = '0;
  logic [63:0] m_hpm = '0;
  logic [31:0] m_inh = '0;

  // Expected {hit, data} for a read address, from the model state
  function automatic logic [32:0] model_read(input logic [11:0] a);
    logic [32:0] r;
    case (a)
      12'hB00, 12'hC00: r = {1'b1, m_cyc[31:0]};
      12'hB80, 12'hC80: r = {1'b1, m_cyc[63:32]};
      12'hB02, 12'hC02: r = {1'b1, m_ins[31:0]};
      12'hB82, 12'hC82: r = {1'b1, m_ins[63:32]};
      12'h320:          r = {1'b1, m_inh};
`ifdef CSR_PERF_HPM_STALL_EN
      12'hB03, 12'hC03: r = {1'b1, m_hpm[31:0]};
      12'hB83, 12'hC83: r = {1'b1, m_hpm[63:32]};
`endif
      default:          r = 33'd0;
    endcase
    if (reset) r[31:0] = 32'd0;
    return r;
  endfunction

  // One counter's next value: a write to either half wins, otherwise +1
  function automatic logic [63:0] model_cnt(input logic [63:0] cur, input logic inc,
                                            input logic [11:0] lo_a, input logic [11:0] hi_a);
    if (csr_we && csr_waddr == lo_a) return {cur[63:32], csr_wdata};
    if (csr_we && csr_waddr == hi_a) return {csr_wdata, cur[31:0]};
    if (inc) return cur + 64'd1;
    return cur;
  endfunction

  // Apply one clock edge with the currently driven inputs, advance the model
  task automatic step();
    logic [63:0] nc, ni, nh;
    logic [31:0] ninh;
    if (reset) begin
      nc = '0; ni = '0; nh = '0; ninh = '0;
    end else begin
      nc   = model_cnt(m_cyc, !m_inh[0], 12'hB00, 12'hB80);
      ni   = model_cnt(m_ins, valid_w && !stall_w && !m_inh[2], 12'hB02, 12'hB82);
`ifdef CSR_PERF_HPM_STALL_EN
      nh   = model_cnt(m_hpm, valid_w && stall_w && !m_inh[3], 12'hB03, 12'hB83);
`else
      nh   = m_hpm;
`endif
      ninh = (csr_we && csr_waddr == 12'h320) ? (csr_wdata & INH_MASK) : m_inh;
    end
    @(posedge clk);
    #1;
    m_cyc = nc; m_ins = ni; m_hpm = nh; m_inh = ninh;
  endtask

  task automatic drive(input logic v, input logic s, input logic we,
                       input logic [11:0] wa, input logic [31:0] wd);
    valid_w = v; stall_w = s; csr_we = we; csr_waddr = wa; csr_wdata = wd;
  endtask

  task automatic test_reset();
    logic [32:0] exp;
    logic [11:0] addrs [3] = '{12'hB00, 12'hB02, 12'h320};
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      foreach (addrs[k]) begin
        csr_raddr = addrs[k]; #1;
        checks++;
        if (csr_rdata !== 32'd0 || csr_hit !== 1'b1) begin
          errors++;
          $display("FAIL reset_hold addr=%h got=%h/%b exp=0/1", addrs[k], csr_rdata, csr_hit);
        end
      end
    end
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      csr_raddr = 12'hB00; #1;
      checks++;
      if (csr_rdata !== 32'(c)) begin
        errors++;
        $display("FAIL reset_release_mcycle got=%h exp=%h", csr_rdata, 32'(c));
      end
      csr_raddr = 12'hB02; #1;
      exp = model_read(12'hB02);
      checks++;
      if (csr_rdata !== 32'd0 || csr_rdata !== exp[31:0]) begin
        errors++;
        $display("FAIL reset_release_minstret got=%h exp=0", csr_rdata);
      end
    end
  endtask

  task automatic test_retire();
    logic [63:0] c0, i0;
    c0 = m_cyc; i0 = m_ins;
    for (int c = 1; c <= 10; c++) begin
      drive(1'b1, (c >= 4 && c <= 6), 1'b0, 12'h000, 32'd0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
    csr_raddr = 12'hB02; #1;
    checks++;
    if (csr_rdata !== i0[31:0] + 32'd7) begin
      errors++;
      $display("FAIL retire_minstret got=%h exp=%h", csr_rdata, i0[31:0] + 32'd7);
    end
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== c0[31:0] + 32'd10) begin
      errors++;
      $display("FAIL retire_mcycle got=%h exp=%h", csr_rdata, c0[31:0] + 32'd10);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_lo [4] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp_hi [4] = '{32'd0, 32'd1, 32'd0, 32'd0};
    drive(1'b0, 1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF); step();
    drive(1'b0, 1'b0, 1'b1, 12'hB80, 32'd0);         step();
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        drive(1'b0, 1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF); step();
        drive(1'b0, 1'b0, 1'b1, 12'hB80, 32'hFFFF_FFFF); step();
        drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);         step();
      end
      for (int k = 0; k < 2; k++) begin
        if (p == 0 && k == 1) begin
          drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0); step();
        end
        csr_raddr = 12'hB00; #1;
        checks++;
        if (csr_rdata !== exp_lo[2*p+k]) begin
          errors++;
          $display("FAIL wrap_lo phase=%0d got=%h exp=%h", 2*p+k, csr_rdata, exp_lo[2*p+k]);
        end
        csr_raddr = 12'hB80; #1;
        checks++;
        if (csr_rdata !== exp_hi[2*p+k]) begin
          errors++;
          $display("FAIL wrap_hi phase=%0d got=%h exp=%h", 2*p+k, csr_rdata, exp_hi[2*p+k]);
        end
        if (p == 1) break;
      end
    end
  endtask

  task automatic test_collision();
    logic [63:0] c0;
    c0 = m_cyc;
    drive(1'b1, 1'b0, 1'b1, 12'hB02, 32'h100); step();
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
    csr_raddr = 12'hB02; #1;
    checks++;
    if (csr_rdata !== 32'h100) begin
      errors++;
      $display("FAIL collision_minstret got=%h exp=%h", csr_rdata, 32'h100);
    end
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== c0[31:0] + 32'd1) begin
      errors++;
      $display("FAIL collision_mcycle got=%h exp=%h", csr_rdata, c0[31:0] + 32'd1);
    end
  endtask

  task automatic test_inhibit();
    logic [31:0] c0, i0;
    drive(1'b0, 1'b0, 1'b1, 12'h320, 32'hFFFF_FFF5); step();
    c0 = m_cyc[31:0]; i0 = m_ins[31:0];
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 1'b0, 12'h000, 32'd0); step();
    end
    // The write of 0 still sees the old inhibit on its own edge.
    drive(1'b1, 1'b0, 1'b1, 12'h320, 32'd0); step();
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== c0) begin
      errors++;
      $display("FAIL inhibit_mcycle_frozen got=%h exp=%h", csr_rdata, c0);
    end
    csr_raddr = 12'hB02; #1;
    checks++;
    if (csr_rdata !== i0) begin
      errors++;
      $display("FAIL inhibit_minstret_frozen got=%h exp=%h", csr_rdata, i0);
    end
    drive(1'b1, 1'b0, 1'b0, 12'h000, 32'd0); step();
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== c0 + 32'd1) begin
      errors++;
      $display("FAIL inhibit_mcycle_resume got=%h exp=%h", csr_rdata, c0 + 32'd1);
    end
    csr_raddr = 12'hB02; #1;
    checks++;
    if (csr_rdata !== i0 + 32'd1) begin
      errors++;
      $display("FAIL inhibit_minstret_resume got=%h exp=%h", csr_rdata, i0 + 32'd1);
    end
  endtask

  task automatic test_inhibit_readback();
    drive(1'b0, 1'b0, 1'b1, 12'h320, 32'hFFFF_FFFF); step();
    csr_raddr = 12'h320; #1;
    checks++;
    if (csr_rdata !== INH_MASK) begin
      errors++;
      $display("FAIL inhibit_readback got=%h exp=%h", csr_rdata, INH_MASK);
    end
    drive(1'b0, 1'b0, 1'b1, 12'h320, 32'd0); step();
  endtask

  task automatic test_shadow();
    logic [32:0] exp;
    logic [31:0] c0;
    logic [11:0] addrs [4] = '{12'hC00, 12'hC82, 12'h7C0, 12'hB83};
    drive(1'b1, 1'b0, 1'b1, 12'hB82, 32'h0000_00A5); step();
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
    foreach (addrs[k]) begin
      csr_raddr = addrs[k]; #1;
      exp = model_read(addrs[k]);
      checks++;
      if ({csr_hit, csr_rdata} !== exp) begin
        errors++;
        $display("FAIL shadow_read addr=%h got=%b/%h exp=%b/%h",
                 addrs[k], csr_hit, csr_rdata, exp[32], exp[31:0]);
      end
    end
    c0 = m_cyc[31:0];
    drive(1'b0, 1'b0, 1'b1, 12'hC00, 32'h1234_5678); step();
    csr_raddr = 12'hB00; #1;
    checks++;
    if (csr_rdata !== c0 + 32'd1) begin
      errors++;
      $display("FAIL shadow_write_ignored got=%h exp=%h", csr_rdata, c0 + 32'd1);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp;
    logic [11:0] addrs [16] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h320,
                                12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hB03,
                                12'hB83, 12'hC03, 12'hC83, 12'h7C0, 12'hB01, 12'h000};
    logic [11:0] wa, ra;
    logic [31:0] wd;
    for (int n = 0; n < 600; n++) begin
      wa = addrs[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1:       wd = 32'($urandom_range(0, 7));
        default: wd = $urandom;
      endcase
      if (wa == 12'h320 && $urandom_range(0, 1) == 1) wd = wd & 32'hFFFF_FFF0;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), wa, wd);
      reset = ($urandom_range(0, 99) == 0);
      // Pre-edge read, often of the CSR being written: sees old value
      ra = ($urandom_range(0, 1) == 1) ? wa : addrs[$urandom_range(0, 15)];
      csr_raddr = ra; #1;
      exp = model_read(ra);
      checks++;
      if ({csr_hit, csr_rdata} !== exp) begin
        errors++;
        $display("FAIL rand_pre n=%0d addr=%h got=%b/%h exp=%b/%h",
                 n, ra, csr_hit, csr_rdata, exp[32], exp[31:0]);
      end
      step();
      reset = 1'b0;
      ra = addrs[$urandom_range(0, 15)];
      csr_raddr = ra; #1;
      exp = model_read(ra);
      checks++;
      if ({csr_hit, csr_rdata} !== exp) begin
        errors++;
        $display("FAIL rand_post n=%0d addr=%h got=%b/%h exp=%b/%h",
                 n, ra, csr_hit, csr_rdata, exp[32], exp[31:0]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    csr_raddr = 12'h000;
    drive(1'b0, 1'b0, 1'b0, 12'h000, 32'd0);
    test_reset();
    test_retire();
    test_wrap();
    test_collision();
    test_inhibit();
    test_inhibit_readback();
    test_shadow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_perf_counters.md
Name: csr_perf_counters

Overview:
- Machine-mode performance counter block downstream of the writeback stage.
- Consumes the writeback retire qualifiers (valid_w, stall_w) and the writeback CSR write port.
- Maintains the architectural mcycle and minstret counters and the mcountinhibit register.
- Serves combinational CSR reads to the CSR read mux in execute.

Parameters:
CNT_WIDTH, 64, implemented counter width (legal range 33..64); bits above CNT_WIDTH-1 read as zero in the high-half CSRs.

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
valid_w_i  input  1  writeback holds a valid instruction
stall_w_i  input  1  writeback stage stalled this cycle
csr_we_w_i  input  1  CSR write strobe from writeback
csr_addr_w_i  input  12  CSR write address
csr_wdata_w_i  input  32  CSR write data (final result after RW/RS/RC resolution)
csr_raddr_i  input  12  CSR read address
csr_rdata_o  output  32  CSR read data
csr_hit_o  output  1  csr_raddr_i decodes to a CSR implemented by this block

Behaviour:
- Single clock domain, clk_i. Reset is synchronous and active-high on reset_i.
- Reset (next rising edge with reset_i=1): mcycle=0, minstret=0, mcountinhibit=0. Reset overrides any write or increment in the same cycle. Reset asserted mid-count clears the counters on that edge.
- Outputs are combinational from registered state plus csr_raddr_i. With reset held, csr_rdata_o reads 0 for every address.
- Retire event: retire = valid_w_i & ~stall_w_i.
- mcycle: increments by 1 every cycle unless mcountinhibit[0]=1.
- minstret: increments by 1 on each retire cycle unless mcountinhibit[2]=1.
- Arithmetic is modulo 2^CNT_WIDTH. The all-ones value wraps to 0 with no flag.
- Address map. Read/write: mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82, mcountinhibit 0x320. Read-only shadows: cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82.
- Low-half reads return counter[31:0]. High-half reads return counter[CNT_WIDTH-1:32], zero-extended.
- mcountinhibit stores bits 0 and 2 only (bit 3 with the optional feature). All other bits read 0.
- Writes take effect at the clock edge on which csr_we_w_i=1 and csr_addr_w_i matches a read/write address. Writes to read-only shadows or unmapped addresses are ignored and change no state.
- Write to a low half: counter[31:0]=wdata, high half unchanged.
- Write to a high half: counter[CNT_WIDTH-1:32]=wdata truncated to width, low half unchanged.
- Write vs. increment collision: a write to either half of a counter suppresses that counter's increment on that edge. The write wins and no carry is applied. The other counter still counts normally.
- mcountinhibit write: takes effect for increments from the next edge onward. The edge of the write itself uses the old inhibit value.
- Read during write to the same CSR returns the pre-write value.
- csr_hit_o=1 for every mapped address, including read-only shadows. Unmapped addresses give csr_hit_o=0 and csr_rdata_o=0.

Optional Feature:
Macro: CSR_PERF_HPM_STALL_EN.
- Defined:
  - Adds mhpmcounter3 (0xB03/0xB83, read/write) with read-only shadows hpmcounter3 (0xC03/0xC83).
  - Counts cycles with valid_w_i & stall_w_i.
  - Inhibited by mcountinhibit[3], which becomes writable.
  - Same reset, width, wrap and collision rules as the other counters.
- Undefined: those four addresses give csr_hit_o=0, mcountinhibit[3] reads 0, and no extra flops exist.

Test Plan:
- Reset held 3 cycles then released, valid_w_i=0 -> mcycle reads 0 during reset, then 1, 2, 3 on successive cycles; minstret stays 0.
- valid_w_i=1 for 10 cycles with stall_w_i=1 on cycles 4-6 -> minstret=7, mcycle advances 10.
- Write mcycle=0xFFFFFFFF and mcycleh=0 on consecutive edges, then free-run -> low half wraps to 0 with mcycleh=1 one cycle after the last write. With CNT_WIDTH=64 and all-ones, the counter wraps to 0.
- Write minstret=0x100 on a retire cycle -> reads 0x100 next cycle (no increment applied); mcycle unaffected.
- Write mcountinhibit=0x5, then retire 4 instructions -> mcycle and minstret frozen. Write 0x0 -> counting resumes the edge after.
- Read 0xC00, 0xC82, 0x7C0 -> hit=1 and values equal mcycle low / minstret high; 0x7C0 gives hit=0 and data=0. A write to 0xC00 leaves mcycle unchanged.
